aes_enc_iter: RTL and testbench

Iterative, parametrised AES block encryptor computing one round per clock. Supports 128-bit and 256-bit keys selected by parameter and computes the key schedule on the fly. Uses valid/ready handshakes on both sides. Sits between a block source and a ciphertext sink as the clocked successor to the team's single-shot combinational AES-128 encryptor.

---
 rtl/aes_enc_iter.sv | 201 ++++++++++++++++++++
 tb/tb_aes_enc_iter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_iter.sv
// Iterative AES encryptor: one round per clock, AES-128 or AES-256 chosen by KEY_BITS,
// with the key schedule expanded on the fly from a rolling key window.
module aes_enc_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:127]        plaintext,
    input  logic [0:KEY_BITS-1] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:127]        ciphertext,
    output logic                busy
);

    localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

    // Handshake: a transfer happens on a rising edge where valid && ready; the source
    // holds its data stable until then, the sink sees ciphertext held while out_valid=1.
    state_e              fsm_q, fsm_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [0:127]        st_q, st_d;
    logic [0:KEY_BITS-1] kw_q, kw_d, kw_next;
    logic                ov_q, ov_d, busy_q, busy_d;
    logic [0:127]        rk;
    logic [0:127]        round_out;
    logic                accept;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq  = x;
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    if (KEY_BITS == 256) begin : g_ks256
        // Window holds {rk[r-2], rk[r-1]}; round 1 uses the upper key half untouched.
        logic [0:127] lo, hi;
        logic [31:0]  b3, t, w0, w1, w2, w3;
        always_comb begin
            lo = kw_q[0:127];
            hi = kw_q[128:255];
            b3 = hi[96:127];
            if (!rnd_q[0]) t = subword({b3[23:0], b3[31:24]}) ^ {rcon({1'b0, rnd_q[3:1]}), 24'h0};
            else           t = subword(b3);
            w0 = lo[0:31] ^ t;
            w1 = lo[32:63] ^ w0;
            w2 = lo[64:95] ^ w1;
            w3 = lo[96:127] ^ w2;
            if (rnd_q == 4'd1) begin
                rk      = hi;
                kw_next = kw_q;
            end else begin
                rk      = {w0, w1, w2, w3};
                kw_next = {hi, w0, w1, w2, w3};
            end
        end
    end else begin : g_ks128
        logic [31:0] t, w0, w1, w2, w3;
        always_comb begin
            t  = subword({kw_q[104:127], kw_q[96:103]}) ^ {rcon(rnd_q), 24'h0};
            w0 = kw_q[0:31] ^ t;
            w1 = kw_q[32:63] ^ w0;
            w2 = kw_q[64:95] ^ w1;
            w3 = kw_q[96:127] ^ w2;
            rk      = {w0, w1, w2, w3};
            kw_next = rk;
        end
    end

    // State bytes are column-major: byte 4*c+row.
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];
    always_comb begin
        for (int b = 0; b < 16; b++) sb[b] = sbox(st_q[8*b +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
        end
        for (int b = 0; b < 16; b++)
            round_out[8*b +: 8] = ((rnd_q == NR) ? sr[b] : mc[b]) ^ rk[8*b +: 8];
    end

    assign in_ready = rst_n && ((fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        fsm_d  = fsm_q;
        rnd_d  = rnd_q;
        st_d   = st_q;
        kw_d   = kw_q;
        ov_d   = ov_q;
        busy_d = busy_q;
        case (fsm_q)
            S_IDLE: ;
            S_ROUND: begin
                st_d = round_out;
                kw_d = kw_next;
                if (rnd_q == NR) begin
                    fsm_d = S_DONE;
                    rnd_d = 4'd0;
                    ov_d  = 1'b1;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d  = S_IDLE;
                    ov_d   = 1'b0;
                    busy_d = 1'b0;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        // Accept from IDLE or from DONE on the same edge the result is taken.
        if (accept) begin
            fsm_d  = S_ROUND;
            rnd_d  = 4'd1;
            st_d   = plaintext ^ key[0:127];
            kw_d   = key;
            ov_d   = 1'b0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            rnd_q  <= 4'd0;
            st_q   <= '0;
            kw_q   <= '0;
            ov_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            rnd_q  <= rnd_d;
            st_q   <= st_d;
            kw_q   <= kw_d;
            ov_q   <= ov_d;
            busy_q <= busy_d;
        end
    end

    assign out_valid  = ov_q;
    assign busy       = busy_q;
    assign ciphertext = st_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 vectors on an AES-128 and an AES-256 instance,
// latency/throughput, back-pressure, input mutation during rounds and mid-round reset.
module tb_aes_enc_iter;

    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk, rst_n;
    logic         iv128, ir128, ov128, or128, busy128;
    logic [0:127] pt128, k128, ct128;
    logic         iv256, ir256, ov256, or256, busy256;
    logic [0:127] pt256, ct256;
    logic [0:255] k256;

    int tests = 0;
    int fails = 0;
    int n;
    logic seen;

    aes_enc_iter #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv128), .in_ready(ir128),
        .plaintext(pt128), .key(k128), .out_valid(ov128), .out_ready(or128),
        .ciphertext(ct128), .busy(busy128)
    );

    aes_enc_iter #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv256), .in_ready(ir256),
        .plaintext(pt256), .key(k256), .out_valid(ov256), .out_ready(or256),
        .ciphertext(ct256), .busy(busy256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input bit sel256, output int cnt);
        cnt = 0;
        while (!(sel256 ? ov256 : ov128) && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic accept128(input logic [127:0] pt, input logic [127:0] k);
        iv128 = 1'b1;
        pt128 = pt;
        k128  = k;
        check("in_ready_before_accept", 256'(ir128), 256'd1);
        tick();
        iv128 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        iv128 = 1'b0; pt128 = '0; k128 = '0; or128 = 1'b1;
        iv256 = 1'b0; pt256 = '0; k256 = '0; or256 = 1'b1;
        repeat (3) tick();
        check("rst_in_ready_low", 256'(ir128), 256'd0);
        check("rst_out_valid", 256'(ov128), 256'd0);
        check("rst_busy", 256'(busy128), 256'd0);
        check("rst_ciphertext_128", 256'(ct128), 256'd0);
        check("rst_ciphertext_256", 256'(ct256), 256'd0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready_128", 256'(ir128), 256'd1);
        check("idle_in_ready_256", 256'(ir256), 256'd1);
        check("idle_busy_256", 256'(busy256), 256'd0);

        // FIPS-197 Appendix B vector, single block.
        accept128(PT_A, KEY_A);
        check("busy_after_accept", 256'(busy128), 256'd1);
        check("ov_after_accept", 256'(ov128), 256'd0);
        wait_out(1'b0, n);
        check("latency_128", 256'(n), 256'd10);
        check("ct_fips_b", 256'(ct128), 256'(CT_A));
        tick();
        check("ov_one_cycle", 256'(ov128), 256'd0);
        check("busy_back_idle", 256'(busy128), 256'd0);

        // Back-to-back blocks with in_valid held: second accept on the DONE edge.
        iv128 = 1'b1; pt128 = PT_B; k128 = KEY_B;
        tick();
        wait_out(1'b0, n);
        check("latency_b2b_first", 256'(n), 256'd10);
        check("ct_fips_c1_first", 256'(ct128), 256'(CT_B));
        check("in_ready_done_sink_ready", 256'(ir128), 256'd1);
        tick();
        check("ov_after_b2b_accept", 256'(ov128), 256'd0);
        check("busy_after_b2b_accept", 256'(busy128), 256'd1);
        iv128 = 1'b0;
        wait_out(1'b0, n);
        check("latency_b2b_second", 256'(n), 256'd10);
        check("ct_fips_c1_second", 256'(ct128), 256'(CT_B));
        tick();

        // AES-256, FIPS-197 Appendix C.3.
        iv256 = 1'b1; pt256 = PT_B; k256 = KEY_C;
        check("in_ready_256", 256'(ir256), 256'd1);
        tick();
        iv256 = 1'b0;
        wait_out(1'b1, n);
        check("latency_256", 256'(n), 256'd14);
        check("ct_fips_c3", 256'(ct256), 256'(CT_C));
        tick();
        check("ov_256_one_cycle", 256'(ov256), 256'd0);

        // Back-pressure held for 20 cycles, then same-edge accept of the next block.
        or128 = 1'b0;
        accept128(PT_A, KEY_A);
        wait_out(1'b0, n);
        check("latency_bp", 256'(n), 256'd10);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!ov128 || ct128 !== CT_A || ir128) seen = 1'b1;
        end
        check("bp_hold_stable", 256'(seen), 256'd0);
        check("bp_ct", 256'(ct128), 256'(CT_A));
        check("bp_in_ready_low", 256'(ir128), 256'd0);
        or128 = 1'b1; iv128 = 1'b1; pt128 = PT_B; k128 = KEY_B;
        #1;
        check("bp_release_in_ready", 256'(ir128), 256'd1);
        tick();
        iv128 = 1'b0;
        check("bp_same_edge_busy", 256'(busy128), 256'd1);
        check("bp_same_edge_ov", 256'(ov128), 256'd0);
        wait_out(1'b0, n);
        check("bp_second_latency", 256'(n), 256'd10);
        check("bp_second_ct", 256'(ct128), 256'(CT_B));
        tick();

        // Inputs scrambled every cycle during rounds; sink stalled so DONE holds.
        or128 = 1'b0;
        accept128(PT_B, KEY_B);
        n = 0;
        seen = 1'b0;
        while (!ov128 && n < 40) begin
            pt128 = {$urandom, $urandom, $urandom, $urandom};
            k128  = {$urandom, $urandom, $urandom, $urandom};
            iv128 = 1'($urandom_range(0, 1));
            if (ir128) seen = 1'b1;
            tick();
            n++;
        end
        check("mut_in_ready_low_rounds", 256'(seen), 256'd0);
        check("mut_latency", 256'(n), 256'd10);
        check("mut_ct", 256'(ct128), 256'(CT_B));
        iv128 = 1'b0; or128 = 1'b1;
        tick();
        check("mut_no_extra_accept", 256'(busy128), 256'd0);
        check("mut_ov_clear", 256'(ov128), 256'd0);

        // Reset in the middle of round 5.
        accept128(PT_A, KEY_A);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_ov", 256'(ov128), 256'd0);
        check("rst_mid_busy", 256'(busy128), 256'd0);
        check("rst_mid_in_ready", 256'(ir128), 256'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 256'(ir128), 256'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov128 || busy128) seen = 1'b1;
        end
        check("post_rst_no_output", 256'(seen), 256'd0);
        accept128(PT_A, KEY_A);
        wait_out(1'b0, n);
        check("post_rst_latency", 256'(n), 256'd10);
        check("post_rst_ct", 256'(ct128), 256'(CT_A));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
